// File: rtl/compare_sequencer.sv
// Registered valid/ready front/back end for a combinational 5-bit magnitude comparator.
// Drives PORTA/PORTB, waits SETTLE cycles, samples EQUAL/LESS/HIGHER and keeps outcome counters.
module compare_sequencer #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [4:0]       IN_A,
   input  logic [4:0]       IN_B,
   output logic [4:0]       PORTA,
   output logic [4:0]       PORTB,
   input  logic             EQUAL,
   input  logic             LESS,
   input  logic             HIGHER,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             OUT_EQ,
   output logic             OUT_LT,
   output logic             OUT_GT,
   output logic [CNT_W-1:0] CNT_EQ,
   output logic [CNT_W-1:0] CNT_LT,
   output logic [CNT_W-1:0] CNT_GT,
   output logic             ERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       sample;
   logic       handoff;
   logic [2:0] flags;
   logic       one_hot;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign flags    = {EQUAL, LESS, HIGHER};
   assign one_hot  = $onehot(flags);
   assign IN_READY = (state == IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sample    = 1'b0;
      handoff   = 1'b0;
      unique case (state)
         IDLE: if (IN_VALID) begin
            accept    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (settle_cnt == 4'd0) begin
            sample    = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: if (OUT_READY) begin
            handoff   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PORTA      <= '0;
         PORTB      <= '0;
         settle_cnt <= '0;
         OUT_EQ     <= 1'b0;
         OUT_LT     <= 1'b0;
         OUT_GT     <= 1'b0;
         OUT_VALID  <= 1'b0;
      end else begin
         if (accept) begin
            PORTA      <= IN_A;
            PORTB      <= IN_B;
            settle_cnt <= SETTLE_CNT;
         end else if (state == WAIT && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         // Raw flags are delivered even when they are not one-hot.
         if (sample) begin
            OUT_EQ    <= EQUAL;
            OUT_LT    <= LESS;
            OUT_GT    <= HIGHER;
            OUT_VALID <= 1'b1;
         end else if (handoff) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

   // CLR has priority over a coincident sample.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CNT_EQ <= '0;
         CNT_LT <= '0;
         CNT_GT <= '0;
         ERR    <= 1'b0;
      end else if (CLR) begin
         CNT_EQ <= '0;
         CNT_LT <= '0;
         CNT_GT <= '0;
         ERR    <= 1'b0;
      end else if (sample) begin
         if (one_hot) begin
            if (EQUAL)  CNT_EQ <= sat_inc(CNT_EQ);
            if (LESS)   CNT_LT <= sat_inc(CNT_LT);
            if (HIGHER) CNT_GT <= sat_inc(CNT_GT);
         end else begin
            ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_compare_sequencer.sv
// Bench for compare_sequencer: two instances (SETTLE=1/CNT_W=2 and SETTLE=3/CNT_W=8),
// a comparator model with a flag override, and a counter/flag reference model.
`timescale 1ns/1ps
module tb_compare_sequencer;

   localparam int SETTLE1 = 1;
   localparam int CNT_W1  = 2;
   localparam int SAT1    = 3;
   localparam int SETTLE3 = 3;
   localparam int CNT_W3  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, clr, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]        in_a, in_b, porta, portb;
   logic              equal, less, higher, out_eq, out_lt, out_gt, err;
   logic [CNT_W1-1:0] cnt_eq, cnt_lt, cnt_gt;
   logic              force_en;
   logic [2:0]        force_flags;

   logic              rst3_n, clr3, in_valid3, in_ready3, out_valid3, out_ready3;
   logic [4:0]        in_a3, in_b3, porta3, portb3;
   logic              equal3, less3, higher3, out_eq3, out_lt3, out_gt3, err3;
   logic [CNT_W3-1:0] cnt_eq3, cnt_lt3, cnt_gt3;

   int         checks = 0;
   int         errors = 0;
   int         m_eq, m_lt, m_gt;
   bit         m_err;
   logic [2:0] last_f;
   int         m3_eq, m3_lt, m3_gt;

   // Comparator models; instance 1 can be overridden to produce illegal flag sets.
   assign {equal, less, higher} = force_en ? force_flags
                                           : {porta == portb, porta < portb, porta > portb};
   assign {equal3, less3, higher3} = {porta3 == portb3, porta3 < portb3, porta3 > portb3};

   compare_sequencer #(.SETTLE(SETTLE1), .CNT_W(CNT_W1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .CLR(clr), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_A(in_a), .IN_B(in_b), .PORTA(porta), .PORTB(portb),
      .EQUAL(equal), .LESS(less), .HIGHER(higher),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_EQ(out_eq), .OUT_LT(out_lt), .OUT_GT(out_gt),
      .CNT_EQ(cnt_eq), .CNT_LT(cnt_lt), .CNT_GT(cnt_gt), .ERR(err));

   compare_sequencer #(.SETTLE(SETTLE3), .CNT_W(CNT_W3)) u_dut3 (
      .CLK(clk), .RST_N(rst3_n), .CLR(clr3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
      .IN_A(in_a3), .IN_B(in_b3), .PORTA(porta3), .PORTB(portb3),
      .EQUAL(equal3), .LESS(less3), .HIGHER(higher3),
      .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
      .OUT_EQ(out_eq3), .OUT_LT(out_lt3), .OUT_GT(out_gt3),
      .CNT_EQ(cnt_eq3), .CNT_LT(cnt_lt3), .CNT_GT(cnt_gt3), .ERR(err3));

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model for one sample: CLR wins, one-hot flags bump a saturating count,
   // anything else sets the sticky error.
   task automatic model_sample(input logic [2:0] f, input bit clr_s);
      if (clr_s) begin
         m_eq = 0; m_lt = 0; m_gt = 0; m_err = 0;
      end else if ($countones(f) == 1) begin
         if (f == 3'b100) m_eq = (m_eq < SAT1) ? m_eq + 1 : SAT1;
         if (f == 3'b010) m_lt = (m_lt < SAT1) ? m_lt + 1 : SAT1;
         if (f == 3'b001) m_gt = (m_gt < SAT1) ? m_gt + 1 : SAT1;
      end else begin
         m_err = 1;
      end
   endtask

   // One full transaction on instance 1, starting and ending at a falling edge in IDLE.
   task automatic transact(input logic [4:0] a, input logic [4:0] b, input bit fe,
                           input logic [2:0] ff, input bit clr_s, input int hold,
                           input bit stall, output time t_acc);
      int lat;
      logic [2:0] exp_f;
      exp_f = fe ? ff : {a == b, a < b, a > b};
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", in_ready); end
      force_flags = ff;
      force_en    = fe;
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      in_valid = 1'b0; in_a = 5'($urandom); in_b = 5'($urandom);
      checks++;
      if (porta !== a || portb !== b) begin
         errors++; $display("FAIL ports got %0d/%0d exp %0d/%0d", porta, portb, a, b);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL wait_hs got ready=%b valid=%b exp 0/0", in_ready, out_valid);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         clr       = clr_s && (lat == SETTLE1);
         out_ready = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
         clr = 1'b0;
      end
      model_sample(exp_f, clr_s);
      checks++;
      if (lat != SETTLE1 + 1) begin errors++; $display("FAIL latency got %0d exp %0d", lat, SETTLE1 + 1); end
      checks++;
      if ({out_eq, out_lt, out_gt} !== exp_f) begin
         errors++; $display("FAIL out_flags got %b exp %b", {out_eq, out_lt, out_gt}, exp_f);
      end
      checks++;
      if (cnt_eq !== 2'(m_eq) || cnt_lt !== 2'(m_lt) || cnt_gt !== 2'(m_gt)) begin
         errors++; $display("FAIL counters got %0d/%0d/%0d exp %0d/%0d/%0d",
                            cnt_eq, cnt_lt, cnt_gt, m_eq, m_lt, m_gt);
      end
      checks++;
      if (err !== m_err) begin errors++; $display("FAIL err got %b exp %b", err, m_err); end
      force_en  = 1'b0;
      out_ready = 1'b0;
      if (stall) begin
         in_valid = 1'b1; in_a = ~a; in_b = ~b;
      end
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || {out_eq, out_lt, out_gt} !== exp_f || in_ready !== 1'b0 ||
             porta !== a || portb !== b) begin
            errors++;
            $display("FAIL hold_stable got v=%b f=%b r=%b pa=%0d pb=%0d exp 1/%b/0/%0d/%0d",
                     out_valid, {out_eq, out_lt, out_gt}, in_ready, porta, portb, exp_f, a, b);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || porta !== a) begin
         errors++; $display("FAIL handoff got v=%b r=%b pa=%0d exp 0/1/%0d", out_valid, in_ready, porta, a);
      end
      in_valid = 1'b0;
      last_f   = exp_f;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      model_sample(3'b000, 1'b1);
      checks++;
      if (cnt_eq !== 2'd0 || cnt_lt !== 2'd0 || cnt_gt !== 2'd0 || err !== 1'b0) begin
         errors++; $display("FAIL clr got %0d/%0d/%0d err=%b exp 0/0/0 err=0", cnt_eq, cnt_lt, cnt_gt, err);
      end
      checks++;
      if ({out_eq, out_lt, out_gt} !== last_f || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL clr_keeps_out got %b v=%b exp %b v=0", {out_eq, out_lt, out_gt}, out_valid, last_f);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst3_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b/%b exp 1/1", in_ready, in_ready3);
      end
      checks++;
      if (porta !== 5'd0 || portb !== 5'd0 || out_valid !== 1'b0 || {out_eq, out_lt, out_gt} !== 3'b000 ||
          cnt_eq !== 2'd0 || cnt_lt !== 2'd0 || cnt_gt !== 2'd0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_state got pa=%0d pb=%0d v=%b f=%b c=%0d/%0d/%0d e=%b exp zeros",
                            porta, portb, out_valid, {out_eq, out_lt, out_gt}, cnt_eq, cnt_lt, cnt_gt, err);
      end
      @(negedge clk);
      rst_n = 1'b1; rst3_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got r=%b v=%b exp 1/0", in_ready, out_valid);
      end
      m_eq = 0; m_lt = 0; m_gt = 0; m_err = 0; last_f = 3'b000;
      m3_eq = 0; m3_lt = 0; m3_gt = 0;
   endtask

   task automatic test_first();
      time t;
      transact(5'd9, 5'd3, 1'b0, 3'b000, 1'b0, 0, 1'b0, t);
      checks++;
      if (cnt_gt !== 2'd1) begin errors++; $display("FAIL first_cnt_gt got %0d exp 1", cnt_gt); end
   endtask

   task automatic test_back_to_back();
      time t1, t2, t3;
      clr_pulse();
      transact(5'd7,  5'd7,  1'b0, 3'b000, 1'b0, 0, 1'b0, t1);
      transact(5'd0,  5'd31, 1'b0, 3'b000, 1'b0, 0, 1'b0, t2);
      transact(5'd31, 5'd0,  1'b0, 3'b000, 1'b0, 0, 1'b0, t3);
      checks++;
      if (t2 - t1 != 40 || t3 - t2 != 40) begin
         errors++; $display("FAIL b2b_spacing got %0t/%0t exp 40/40", t2 - t1, t3 - t2);
      end
      checks++;
      if (cnt_eq !== 2'd1 || cnt_lt !== 2'd1 || cnt_gt !== 2'd1 || err !== 1'b0) begin
         errors++; $display("FAIL b2b_counts got %0d/%0d/%0d e=%b exp 1/1/1 e=0", cnt_eq, cnt_lt, cnt_gt, err);
      end
   endtask

   task automatic test_hold_stall();
      time t1, t2;
      transact(5'd12, 5'd20, 1'b0, 3'b000, 1'b0, 10, 1'b1, t1);
      transact(~5'd12, ~5'd20, 1'b0, 3'b000, 1'b0, 0, 1'b0, t2);
      checks++;
      if (t2 - t1 != (SETTLE1 + 3 + 10) * 10) begin
         errors++; $display("FAIL stall_spacing got %0t exp %0d", t2 - t1, (SETTLE1 + 3 + 10) * 10);
      end
   endtask

   task automatic test_saturation_clr();
      time t;
      clr_pulse();
      for (int k = 0; k < 5; k++) transact(5'(k * 5), 5'(k * 5), 1'b0, 3'b000, 1'b0, 0, 1'b0, t);
      checks++;
      if (cnt_eq !== 2'd3) begin errors++; $display("FAIL saturate got %0d exp 3", cnt_eq); end
      transact(5'd4, 5'd4, 1'b0, 3'b000, 1'b1, 0, 1'b0, t);
      checks++;
      if (cnt_eq !== 2'd0) begin errors++; $display("FAIL clr_on_sample got %0d exp 0", cnt_eq); end
   endtask

   task automatic test_err_sticky();
      time t;
      transact(5'd3, 5'd3, 1'b1, 3'b011, 1'b0, 0, 1'b0, t);
      checks++;
      if (err !== 1'b1 || out_lt !== 1'b1 || out_gt !== 1'b1) begin
         errors++; $display("FAIL err_set got e=%b lt=%b gt=%b exp 1/1/1", err, out_lt, out_gt);
      end
      transact(5'd1, 5'd2, 1'b0, 3'b000, 1'b0, 1, 1'b0, t);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
      clr_pulse();
   endtask

   task automatic test_random();
      time t;
      logic [4:0] a, b;
      for (int i = 0; i < 30; i++) begin
         a = 5'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
         transact(a, b, $urandom_range(0, 5) == 0, 3'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3), 1'($urandom), t);
      end
   endtask

   task automatic run3(input logic [4:0] a, input logic [4:0] b);
      int lat;
      logic [2:0] exp_f;
      exp_f = {a == b, a < b, a > b};
      checks++;
      if (in_ready3 !== 1'b1) begin errors++; $display("FAIL i3_ready got %b exp 1", in_ready3); end
      in_valid3 = 1'b1; in_a3 = a; in_b3 = b;
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0;
      checks++;
      if (porta3 !== a || portb3 !== b) begin
         errors++; $display("FAIL i3_ports got %0d/%0d exp %0d/%0d", porta3, portb3, a, b);
      end
      lat = 0;
      while (out_valid3 !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (exp_f == 3'b100) m3_eq++;
      if (exp_f == 3'b010) m3_lt++;
      if (exp_f == 3'b001) m3_gt++;
      checks++;
      if (lat != SETTLE3 + 1) begin errors++; $display("FAIL i3_latency got %0d exp %0d", lat, SETTLE3 + 1); end
      checks++;
      if ({out_eq3, out_lt3, out_gt3} !== exp_f) begin
         errors++; $display("FAIL i3_flags got %b exp %b", {out_eq3, out_lt3, out_gt3}, exp_f);
      end
      checks++;
      if (cnt_eq3 !== 8'(m3_eq) || cnt_lt3 !== 8'(m3_lt) || cnt_gt3 !== 8'(m3_gt)) begin
         errors++; $display("FAIL i3_counts got %0d/%0d/%0d exp %0d/%0d/%0d",
                            cnt_eq3, cnt_lt3, cnt_gt3, m3_eq, m3_lt, m3_gt);
      end
      out_ready3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready3 = 1'b0;
      checks++;
      if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
         errors++; $display("FAIL i3_handoff got v=%b r=%b exp 0/1", out_valid3, in_ready3);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      run3(5'd20, 5'd10);
      in_valid3 = 1'b1; in_a3 = 5'd4; in_b3 = 5'd9;
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0;
      @(posedge clk);
      #2 rst3_n = 1'b0;
      #1;
      m3_eq = 0; m3_lt = 0; m3_gt = 0;
      checks++;
      if (out_valid3 !== 1'b0 || porta3 !== 5'd0 || portb3 !== 5'd0 || in_ready3 !== 1'b1 ||
          cnt_gt3 !== 8'd0) begin
         errors++; $display("FAIL wait_abort got v=%b pa=%0d pb=%0d r=%b gt=%0d exp 0/0/0/1/0",
                            out_valid3, porta3, portb3, in_ready3, cnt_gt3);
      end
      @(negedge clk);
      rst3_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid3 !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL lost_result got %0d valid cycles exp 0", seen); end
      run3(5'd4, 5'd9);
      in_valid3 = 1'b1; in_a3 = 5'd15; in_b3 = 5'd15;
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0;
      for (int i = 0; i < 40 && out_valid3 !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #2 rst3_n = 1'b0;
      #1;
      m3_eq = 0; m3_lt = 0; m3_gt = 0;
      checks++;
      if (out_valid3 !== 1'b0 || out_eq3 !== 1'b0 || in_ready3 !== 1'b1 || cnt_lt3 !== 8'd0) begin
         errors++; $display("FAIL hold_abort got v=%b eq=%b r=%b lt=%0d exp 0/0/1/0",
                            out_valid3, out_eq3, in_ready3, cnt_lt3);
      end
      @(negedge clk);
      rst3_n = 1'b1;
      @(negedge clk);
      run3(5'd30, 5'd2);
   endtask

   initial begin
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      force_en = 1'b0; force_flags = 3'b000;
      clr3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_a3 = '0; in_b3 = '0;
      test_reset();
      test_first();
      test_back_to_back();
      test_hold_stall();
      test_saturation_clr();
      test_err_sticky();
      test_random();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
